// File: rtl/dmem_pkg.sv
// Shared definitions for the MIPS data memory load/store unit: access size codes,
// FSM states and the byte-lane helpers used on the store and load paths.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } stateT;

   // Byte enables for an already-aligned access; an illegal size enables nothing.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << lane;
         SZ_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic unsignedFlag);
      logic [7:0]  byteVal;
      logic [15:0] halfVal;
      logic [31:0] result;
      case (lane)
         2'd0:    byteVal = word[7:0];
         2'd1:    byteVal = word[15:8];
         2'd2:    byteVal = word[23:16];
         default: byteVal = word[31:24];
      endcase
      halfVal = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: result = unsignedFlag ? {24'h0, byteVal} : {{24{byteVal[7]}}, byteVal};
         SZ_HALF: result = unsignedFlag ? {16'h0, halfVal} : {{16{halfVal[15]}}, halfVal};
         default: result = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word storage built from four independent byte-lane arrays, each with its own
// write enable, and an asynchronous word-wide read.
module dmem_lane_ram #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr,
   input  logic [3:0]       we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   // One array per byte lane so partial stores never touch the other lanes.
   for (genvar g = 0; g < 4; g++) begin : genLane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (we[g])
            mem[addr] <= wdata[8*g +: 8];
      end

      assign rdata[8*g +: 8] = mem[addr];
   end

endmodule

// File: rtl/data_memory_lsu.sv
// MIPS data memory with load/store front end: one transaction in flight, fixed read latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module data_memory_lsu
   import dmem_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
   parameter int                    READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int IDX_W = $clog2(MEMORY_DEPTH);

   stateT                 state;
   stateT                 nextState;
   logic [1:0]            waitCnt;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      ramIdx;
   logic [1:0]            lane;
   logic                  rangeErr;
   logic                  alignErr;
   logic                  reqErr;
   logic [3:0]            laneWe;
   logic [31:0]           laneWdata;
   logic [31:0]           ramRdata;
   logic                  rspActive;

   logic [31:0]           heldWord;
   logic [1:0]            heldSize;
   logic [1:0]            heldLane;
   logic                  heldUnsigned;
   logic                  heldWrite;
   logic                  heldErr;

   assign req_ready = ~reset & ((state == ST_IDLE) | (state == ST_RESP));
   assign accept    = req_valid & req_ready;

   // Address decode and error classification for the request currently presented.
   always_comb begin
      offset   = req_addr - BASE_ADDR;
      ramIdx   = offset[IDX_W+1:2];
      rangeErr = (req_addr < BASE_ADDR) || ((offset >> 2) >= ADDR_WIDTH'(MEMORY_DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
      lane     = offset[1:0];
      alignErr = ((req_size == SZ_HALF) && offset[0]) ||
                 ((req_size == SZ_WORD) && (offset[1:0] != 2'b00));
`else
      alignErr = 1'b0;
      case (req_size)
         SZ_HALF: lane = {offset[1], 1'b0};
         SZ_WORD: lane = 2'b00;
         default: lane = offset[1:0];
      endcase
`endif
      reqErr = rangeErr | alignErr | (req_size == SZ_ILL);
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      case (req_size)
         SZ_BYTE: laneWdata = {4{req_wdata[7:0]}};
         SZ_HALF: laneWdata = {2{req_wdata[15:0]}};
         default: laneWdata = req_wdata;
      endcase
      laneWe = (accept & req_write & ~reqErr) ? lane_mask(req_size, lane) : 4'b0000;
   end

   dmem_lane_ram #(
      .DEPTH (MEMORY_DEPTH),
      .IDX_W (IDX_W)
   ) uLaneRam (
      .clk   (clk),
      .addr  (ramIdx),
      .we    (laneWe),
      .wdata (laneWdata),
      .rdata (ramRdata)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= nextState;
   end

   // WAIT lasts exactly READ_LATENCY cycles; RESP can take the next request directly.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (accept) nextState = ST_WAIT;
         ST_WAIT: if (waitCnt == 2'(READ_LATENCY - 1)) nextState = ST_RESP;
         ST_RESP: nextState = accept ? ST_WAIT : ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   // The word is captured at acceptance; lane selection and extension wait for the response.
   always_ff @(posedge clk) begin
      if (reset) begin
         waitCnt      <= 2'd0;
         heldWord     <= 32'h0;
         heldSize     <= SZ_BYTE;
         heldLane     <= 2'd0;
         heldUnsigned <= 1'b0;
         heldWrite    <= 1'b0;
         heldErr      <= 1'b0;
      end else if (accept) begin
         waitCnt      <= 2'd0;
         heldWord     <= ramRdata;
         heldSize     <= req_size;
         heldLane     <= lane;
         heldUnsigned <= req_unsigned;
         heldWrite    <= req_write;
         heldErr      <= reqErr;
      end else if (state == ST_WAIT) begin
         waitCnt <= waitCnt + 2'd1;
      end
   end

   assign rspActive = ~reset & (state == ST_RESP);
   assign rsp_valid = rspActive;
   assign rsp_err   = rspActive & heldErr;
   assign rsp_rdata = (rspActive & ~heldErr & ~heldWrite) ?
                      load_extend(heldWord, heldSize, heldLane, heldUnsigned) : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Randomised self-checking bench for data_memory_lsu at READ_LATENCY 1 and 3,
// compared cycle by cycle against a byte-addressed reference memory model.
module tb_data_memory_lsu;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst         [2];
   logic        reqValid    [2];
   logic        reqReady    [2];
   logic        reqWrite    [2];
   logic [1:0]  reqSize     [2];
   logic        reqUnsigned [2];
   logic [31:0] reqAddr     [2];
   logic [31:0] reqWdata    [2];
   logic        rspValid    [2];
   logic [31:0] rspRdata    [2];
   logic        rspErr      [2];

   always #5 clk = ~clk;

   data_memory_lsu #(.ADDR_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1)) dutLat1 (
      .clk(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .req_write(reqWrite[0]), .req_size(reqSize[0]), .req_unsigned(reqUnsigned[0]),
      .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .rsp_valid(rspValid[0]),
      .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]));

   data_memory_lsu #(.ADDR_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(3)) dutLat3 (
      .clk(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .req_write(reqWrite[1]), .req_size(reqSize[1]), .req_unsigned(reqUnsigned[1]),
      .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .rsp_valid(rspValid[1]),
      .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]));

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc;
   bit          rstNow;
   bit          pending;
   int          respCyc;
   int          busyUntil;
   bit          expErr;
   logic [31:0] expRdata;
   bit [7:0]    modelBytes [2][64];

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Reference: memory is a flat little-endian byte array covering the first 16 words.
   task automatic modelAccess(input int k, input bit w, input logic [1:0] sz, input bit u,
                              input logic [31:0] a, input logic [31:0] wd,
                              output bit err, output logic [31:0] rd);
      int          nb;
      logic [31:0] ea;
      logic [31:0] off;
      logic [31:0] v;
      err = 1'b0;
      rd  = 32'h0;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ea  = a;
      if (sz == 2'd3) err = 1'b1;
      if (a < BASE || (a - BASE) >= 32'(4 * DEPTH)) err = 1'b1;
      if (sz != 2'd3 && (a % 32'(nb)) != 0) begin
         if (TRAP) err = 1'b1;
         else ea = a - (a % 32'(nb));
      end
      if (err) return;
      off = ea - BASE;
      if (w) begin
         for (int i = 0; i < nb; i++) modelBytes[k][off + 32'(i)] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(modelBytes[k][off + 32'(i)]) << (8*i));
         if (!u && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
         rd = v;
      end
   endtask

   // One clock cycle: check outputs against the model, then drive the next inputs.
   task automatic applyStimulus(input int k, input bit rstIn, input bit drv, input bit w,
                                input logic [1:0] sz, input bit u, input logic [31:0] a,
                                input logic [31:0] wd, output bit accepted);
      bit    expReady;
      bit    due;
      string pre;
      pre      = $sformatf("L%0d", lat(k));
      expReady = !rstNow && (cyc >= busyUntil);
      due      = pending && (cyc == respCyc) && !rstNow;
      checkOutput({pre, " req_ready"}, 32'(reqReady[k]), 32'(expReady));
      checkOutput({pre, " rsp_valid"}, 32'(rspValid[k]), 32'(due));
      if (due) begin
         checkOutput({pre, " rsp_rdata"}, rspRdata[k], expRdata);
         checkOutput({pre, " rsp_err"}, 32'(rspErr[k]), 32'(expErr));
      end
      if (rstNow) begin
         checkOutput({pre, " reset rsp_rdata"}, rspRdata[k], 32'h0);
         checkOutput({pre, " reset rsp_err"}, 32'(rspErr[k]), 32'h0);
      end
      if (pending && cyc >= respCyc) pending = 1'b0;
      rstNow         = rstIn;
      rst[k]         = rstIn;
      reqValid[k]    = drv;
      reqWrite[k]    = w;
      reqSize[k]     = sz;
      reqUnsigned[k] = u;
      reqAddr[k]     = a;
      reqWdata[k]    = wd;
      accepted = drv && !rstIn && (cyc >= busyUntil);
      if (accepted) begin
         modelAccess(k, w, sz, u, a, wd, expErr, expRdata);
         pending   = 1'b1;
         respCyc   = cyc + 1 + lat(k);
         busyUntil = respCyc;
      end
      if (rstIn) begin
         pending   = 1'b0;
         busyUntil = cyc + 1;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idleCycle(input int k, input bit rstIn);
      bit acc;
      applyStimulus(k, rstIn, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, acc);
   endtask

   task automatic transact(input int k, input bit w, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         applyStimulus(k, 1'b0, 1'b1, w, sz, u, a, wd, acc);
         n++;
      end
      if (!acc) checkOutput("accept timeout", 32'h0, 32'h1);
      n = 0;
      while (pending && n < 20) begin
         idleCycle(k, 1'b0);
         n++;
      end
   endtask

   task automatic randomRequest(output bit w, output logic [1:0] sz, output bit u,
                                output logic [31:0] a, output logic [31:0] wd);
      int r;
      r  = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else             a = BASE + 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
   endtask

   task automatic runSuite(input int k);
      bit          acc;
      bit          w;
      bit          u;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] loadAddr [8];
      int          issued;
      int          n;
      rstNow    = 1'b1;
      pending   = 1'b0;
      busyUntil = 0;
      repeat (3) idleCycle(k, 1'b1);
      idleCycle(k, 1'b0);
      idleCycle(k, 1'b0);
      for (int i = 0; i < 16; i++) transact(k, 1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), $urandom);
      // Word, byte and sign/zero-extension basics.
      transact(k, 1'b1, 2'd2, 1'b0, BASE, 32'hDEAD_BEEF);
      transact(k, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
      transact(k, 1'b1, 2'd0, 1'b0, BASE + 32'd5, 32'h0000_0080);
      transact(k, 1'b0, 2'd0, 1'b0, BASE + 32'd5, 32'h0);
      transact(k, 1'b0, 2'd0, 1'b1, BASE + 32'd5, 32'h0);
      transact(k, 1'b0, 2'd2, 1'b0, BASE + 32'd4, 32'h0);
      // Range, illegal size and alignment handling; word 0 must survive the aliasing store.
      transact(k, 1'b1, 2'd2, 1'b0, BASE + 32'(4 * DEPTH), 32'h1234_5678);
      transact(k, 1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'h0);
      transact(k, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
      transact(k, 1'b1, 2'd3, 1'b0, BASE + 32'd8, 32'hFFFF_FFFF);
      transact(k, 1'b0, 2'd2, 1'b0, BASE + 32'd8, 32'h0);
      transact(k, 1'b0, 2'd2, 1'b0, BASE + 32'd2, 32'h0);
      transact(k, 1'b0, 2'd1, 1'b0, BASE + 32'd7, 32'h0);
      // Eight loads with req_valid held high throughout.
      for (int i = 0; i < 8; i++) loadAddr[i] = BASE + 32'(4 * $urandom_range(0, 15));
      issued = 0;
      n      = 0;
      while (issued < 8 && n < 100) begin
         applyStimulus(k, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, loadAddr[issued], 32'h0, acc);
         if (acc) issued++;
         n++;
      end
      if (issued < 8) checkOutput("back-to-back issue timeout", 32'(issued), 32'd8);
      n = 0;
      while (pending && n < 20) begin
         idleCycle(k, 1'b0);
         n++;
      end
      // Random mix, sometimes back-to-back, sometimes with idle gaps.
      for (int t = 0; t < 40; t++) begin
         randomRequest(w, sz, u, a, wd);
         acc = 1'b0;
         n   = 0;
         while (!acc && n < 20) begin
            applyStimulus(k, 1'b0, 1'b1, w, sz, u, a, wd, acc);
            n++;
         end
         if (!acc) checkOutput("random accept timeout", 32'h0, 32'h1);
         repeat ($urandom_range(0, 1) * $urandom_range(1, 4)) idleCycle(k, 1'b0);
      end
      n = 0;
      while (pending && n < 20) begin
         idleCycle(k, 1'b0);
         n++;
      end
      // Reset during the WAIT of a load drops the response; earlier store persists.
      transact(k, 1'b1, 2'd2, 1'b0, BASE + 32'd12, 32'hC0DE_F00D);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 20) begin
         applyStimulus(k, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'd16, 32'h0, acc);
         n++;
      end
      if (!acc) checkOutput("reset test accept timeout", 32'h0, 32'h1);
      repeat (3) idleCycle(k, 1'b1);
      repeat (4) idleCycle(k, 1'b0);
      transact(k, 1'b0, 2'd2, 1'b0, BASE + 32'd12, 32'h0);
      idleCycle(k, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k]         = 1'b1;
         reqValid[k]    = 1'b0;
         reqWrite[k]    = 1'b0;
         reqSize[k]     = 2'd0;
         reqUnsigned[k] = 1'b0;
         reqAddr[k]     = 32'h0;
         reqWdata[k]    = 32'h0;
      end
      @(negedge clk);
      cyc = 0;
      for (int k = 0; k < 2; k++) runSuite(k);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
